// File: rtl/serial_write_engine.sv
// serial_write_engine
//   Write-side request generator for a compute unit. Data words are queued
//   in a small input FIFO; once a descriptor (base, stride, count) is
//   accepted, one write request per word is issued with serially generated
//   addresses. Completion (done) is signalled only after every issued write
//   has been acknowledged.
//
// Ports
//   ap_clk, areset         clock, asynchronous active-high reset
//   cfg_*                  descriptor handshake (cfg_ready high only in IDLE)
//   data_in_*              write word stream into the input FIFO
//   req_out_*              write request to the cache request path
//   resp_in_valid          one write acknowledgement per cycle
//   busy, done             status: not IDLE / one-cycle completion pulse
//   resp_overflow          sticky: acknowledgement received beyond count
//   fifo_empty, fifo_full  input FIFO status flags
//   stall_cycles           backpressure counter
//
// Optional feature
//   SERIAL_WRITE_ENGINE_PERF_EN: when defined, stall_cycles counts cycles with
//   req_out_valid && !req_out_ready (cleared on descriptor acceptance,
//   saturating). When undefined, stall_cycles is tied to 0.
module serial_write_engine #(
  parameter int ENGINE_ID  = 0,
  parameter int ADDR_W     = 64,
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 16
) (
  input  logic              ap_clk,
  input  logic              areset,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [ADDR_W-1:0] cfg_base_addr,
  input  logic [31:0]       cfg_stride,
  input  logic [31:0]       cfg_count,
  input  logic              data_in_valid,
  input  logic [DATA_W-1:0] data_in,
  output logic              data_in_ready,
  output logic              req_out_valid,
  input  logic              req_out_ready,
  output logic [ADDR_W-1:0] req_out_addr,
  output logic [DATA_W-1:0] req_out_data,
  output logic [7:0]        req_out_id,
  input  logic              resp_in_valid,
  output logic              busy,
  output logic              done,
  output logic              resp_overflow,
  output logic              fifo_empty,
  output logic              fifo_full,
  output logic [31:0]       stall_cycles
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_OCC = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RESP, DONE} state_t;
  state_t state, state_next;

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [AW:0]       occ, occ_next;

  logic [31:0]       count, issued, acked, acked_next, stride;
  logic [ADDR_W-1:0] addr_acc;

  logic accept, push, pop, ack_window, last_hs;

  assign req_out_id    = ENGINE_ID[7:0];
  assign data_in_ready = !fifo_full;

  assign accept     = (state == IDLE) && cfg_valid;
  // Push is gated by the registered full flag, so push-while-full never occurs.
  assign push       = data_in_valid && !fifo_full;
  assign pop        = (state == ISSUE) && (!req_out_valid || req_out_ready) &&
                      !fifo_empty && (issued < count);
  assign ack_window = (state == ISSUE) || (state == WAIT_RESP);
  // Acknowledgement count including one arriving this cycle, saturating at count.
  assign acked_next = (ack_window && resp_in_valid && (acked != count)) ?
                      acked + 32'd1 : acked;
  // The held request is the most recent load, so issued==count means it is the last.
  assign last_hs    = (issued == count) && req_out_valid && req_out_ready;

  always_ff @(posedge ap_clk or posedge areset) begin
    if (areset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:      if (cfg_valid) state_next = (cfg_count == 32'd0) ? DONE : ISSUE;
      ISSUE:     if (last_hs) state_next = (acked_next == count) ? DONE : WAIT_RESP;
      WAIT_RESP: if (acked_next == count) state_next = DONE;
      DONE:      state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  always_comb begin
    cfg_ready = (state == IDLE);
    busy      = (state != IDLE);
    done      = (state == DONE);
  end

  // Input FIFO: storage, pointers and registered flags
  always_ff @(posedge ap_clk) begin
    if (push) mem[wr_ptr] <= data_in;
  end

  always_comb begin
    occ_next = occ;
    if (push && !pop)      occ_next = occ + 1'b1;
    else if (!push && pop) occ_next = occ - 1'b1;
  end

  always_ff @(posedge ap_clk or posedge areset) begin
    if (areset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      occ        <= '0;
      fifo_empty <= 1'b1;
      fifo_full  <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      occ        <= occ_next;
      fifo_empty <= (occ_next == '0);
      fifo_full  <= (occ_next == FULL_OCC);
    end
  end

  // Descriptor state, address generation and output request register
  always_ff @(posedge ap_clk or posedge areset) begin
    if (areset) begin
      count         <= '0;
      stride        <= '0;
      addr_acc      <= '0;
      issued        <= '0;
      acked         <= '0;
      resp_overflow <= 1'b0;
      req_out_valid <= 1'b0;
      req_out_addr  <= '0;
      req_out_data  <= '0;
    end else if (accept) begin
      count         <= cfg_count;
      stride        <= cfg_stride;
      addr_acc      <= cfg_base_addr;
      issued        <= '0;
      acked         <= '0;
      resp_overflow <= 1'b0;
    end else begin
      acked <= acked_next;
      if (ack_window && resp_in_valid && (acked == count)) resp_overflow <= 1'b1;
      if (pop) begin
        req_out_valid <= 1'b1;
        req_out_addr  <= addr_acc;
        req_out_data  <= mem[rd_ptr];
        addr_acc      <= addr_acc + ADDR_W'(stride);
        issued        <= issued + 32'd1;
      end else if (req_out_ready) begin
        req_out_valid <= 1'b0;
      end
    end
  end

`ifdef SERIAL_WRITE_ENGINE_PERF_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  logic [31:0] stall_q;

  always_ff @(posedge ap_clk or posedge areset) begin
    if (areset)                              stall_q <= '0;
    else if (accept)                         stall_q <= '0;
    else if (req_out_valid && !req_out_ready) stall_q <= sat_inc(stall_q);
  end

  assign stall_cycles = stall_q;
`else
  assign stall_cycles = 32'd0;
`endif

endmodule
